// File: rtl/if_id_skid_buffer.sv
// Purpose     : IF/ID pipeline boundary. Valid/ready handshake, a main entry
//               that drives decode directly, and a one-deep skid behind it.
// Latency     : 1 active clock edge from accept to out_valid.
// Backpressure: in_ready = reset_n & ~skid_valid & ~flush. It does not depend on
//               out_ready, so a stall is absorbed by the skid entry.
//
// Ports:
//   clock, reset_n         stage clock; asynchronous active-low reset
//   in_valid/in_ready      fetch handshake; instruction, PC ride with in_valid
//   out_valid/out_ready    decode handshake; out_instruction, out_PC are registered
//   flush                  synchronous squash of every held entry; wins over accept/consume
//   occupancy              entries held (0..2)
//
// NEGEDGE_CAPTURE selects the edge that updates state (1 = falling, 0 = rising).
module if_id_skid_buffer #(
    parameter int                 INSTR_W         = 32,
    parameter int                 PC_W            = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR       = '0,
    parameter int                 NEGEDGE_CAPTURE = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    PC,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instruction,
    output logic [PC_W-1:0]    out_PC,
    input  logic               flush,
    output logic [1:0]         occupancy
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic CAP_INV = (NEGEDGE_CAPTURE != 0);

    // One edge polarity for every flop. XOR with a constant reduces to a wire
    // or a single inverter, so all state shares one capture clock.
    logic cap_clk;
    assign cap_clk = clock ^ CAP_INV;

    state_e             state_q,      state_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q,    main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic consume;

    // Valid bits come from the state, so they cannot disagree with occupancy.
    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_TWO);

    // While reset_n is low, in_ready is forced to 0, so nothing is accepted.
    // During a flush, in_ready is also 0, so a fetch presented in that cycle
    // is not taken and fetch must re-present it.
    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    // ------------------------------------------------------------------
    // State register (includes the entry payloads).
    // ------------------------------------------------------------------
    always_ff @(posedge cap_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // A consume in the same cycle is ignored, so the entry counts as
            // squashed rather than delivered.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        main_instr_d = instruction;
                        main_pc_d    = PC;
                    end
                end
                ST_ONE: begin
                    if (consume && accept) begin
                        main_instr_d = instruction;
                        main_pc_d    = PC;
                    end else if (consume) begin
                        // Clear the payload so decode sees a clean NOP/0.
                        state_d      = ST_EMPTY;
                        main_instr_d = NOP_INSTR;
                        main_pc_d    = '0;
                    end else if (accept) begin
                        // Decode is stalled. Park the new entry behind the
                        // main entry, which stays put to keep the order.
                        state_d      = ST_TWO;
                        skid_instr_d = instruction;
                        skid_pc_d    = PC;
                    end
                end
                ST_TWO: begin
                    // in_ready is 0 here, so only a consume can move the state.
                    if (consume) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                        skid_instr_d = NOP_INSTR;
                        skid_pc_d    = '0;
                    end
                end
                default: begin
                    // Unreachable encoding. Recover to a clean empty stage.
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                    main_pc_d    = '0;
                    skid_instr_d = NOP_INSTR;
                    skid_pc_d    = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. out_* come straight from flops. in_ready is combinational
    // from reset_n, skid_valid and flush.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready        = reset_n & ~skid_valid & ~flush;
        out_valid       = main_valid;
        out_instruction = main_instr_q;
        out_PC          = main_pc_q;
        occupancy       = state_q;
    end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
module tb_if_id_skid_buffer;

    typedef struct {
        logic        iv;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_rdy;   // in_ready before the active edge
        logic        e_vld;   // outputs after the active edge
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        logic [1:0]  e_occ;
    } vec_t;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    // DUT A: default parameters, falling-edge capture, NOP = 0.
    logic        a_iv, a_rdy, a_vld, a_ordy, a_fl;
    logic [31:0] a_ins, a_pc, a_oins, a_opc;
    logic [1:0]  a_occ;

    // DUT B: rising-edge capture, narrow fields, NOP = 16'hF000.
    logic        b_iv, b_rdy, b_vld, b_ordy, b_fl;
    logic [15:0] b_ins, b_oins;
    logic [11:0] b_pc, b_opc;
    logic [1:0]  b_occ;

    if_id_skid_buffer dut_a (
        .clock(clock), .reset_n(rst_n),
        .in_valid(a_iv), .in_ready(a_rdy), .instruction(a_ins), .PC(a_pc),
        .out_valid(a_vld), .out_ready(a_ordy), .out_instruction(a_oins), .out_PC(a_opc),
        .flush(a_fl), .occupancy(a_occ)
    );

    if_id_skid_buffer #(
        .INSTR_W(16), .PC_W(12), .NOP_INSTR(16'hF000), .NEGEDGE_CAPTURE(0)
    ) dut_b (
        .clock(clock), .reset_n(rst_n),
        .in_valid(b_iv), .in_ready(b_rdy), .instruction(b_ins), .PC(b_pc),
        .out_valid(b_vld), .out_ready(b_ordy), .out_instruction(b_oins), .out_PC(b_opc),
        .flush(b_fl), .occupancy(b_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                input logic ordy, input logic fl, input logic e_rdy,
                                input logic e_vld, input logic [31:0] e_ins,
                                input logic [31:0] e_pc, input logic [1:0] e_occ);
        vec_t v;
        v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy; v.fl = fl;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ins = e_ins; v.e_pc = e_pc; v.e_occ = e_occ;
        return v;
    endfunction

    // Called at posedge+1. A captures on the falling edge 4 time units later.
    task automatic apply_a(input string tag, input vec_t v);
        a_iv = v.iv; a_ins = v.ins; a_pc = v.pc; a_ordy = v.ordy; a_fl = v.fl;
        #1;
        chk({tag, ".rdy"}, {31'b0, a_rdy}, {31'b0, v.e_rdy});
        @(negedge clock); #1;
        chk({tag, ".vld"}, {31'b0, a_vld}, {31'b0, v.e_vld});
        chk({tag, ".ins"}, a_oins, v.e_ins);
        chk({tag, ".pc"},  a_opc,  v.e_pc);
        chk({tag, ".occ"}, {30'b0, a_occ}, {30'b0, v.e_occ});
        @(posedge clock); #1;
    endtask

    // Called at posedge+1. B captures on the next rising edge.
    task automatic apply_b(input string tag, input vec_t v);
        b_iv = v.iv; b_ins = v.ins[15:0]; b_pc = v.pc[11:0]; b_ordy = v.ordy; b_fl = v.fl;
        #1;
        chk({tag, ".rdy"}, {31'b0, b_rdy}, {31'b0, v.e_rdy});
        @(posedge clock); #1;
        chk({tag, ".vld"}, {31'b0, b_vld}, {31'b0, v.e_vld});
        chk({tag, ".ins"}, {16'b0, b_oins}, v.e_ins);
        chk({tag, ".pc"},  {20'b0, b_opc},  v.e_pc);
        chk({tag, ".occ"}, {30'b0, b_occ}, {30'b0, v.e_occ});
    endtask

    vec_t va[21];
    vec_t vb[10];

    initial begin
        //            iv  ins          pc     ordy fl  rdy vld e_ins        e_pc   occ
        // Streaming with decode always ready.
        va[0]  = mk(1, 32'h11,       32'h0,  1, 0,  1,  1, 32'h11,      32'h0,  1);
        va[1]  = mk(1, 32'h22,       32'h4,  1, 0,  1,  1, 32'h22,      32'h4,  1);
        va[2]  = mk(1, 32'h33,       32'h8,  1, 0,  1,  1, 32'h33,      32'h8,  1);
        va[3]  = mk(1, 32'h44,       32'hC,  1, 0,  1,  1, 32'h44,      32'hC,  1);
        va[4]  = mk(0, 32'hX,        32'hX,  1, 0,  1,  0, 32'h0,       32'h0,  0);
        // Stall with skid.
        va[5]  = mk(1, 32'hA0,       32'h10, 1, 0,  1,  1, 32'hA0,      32'h10, 1);
        va[6]  = mk(1, 32'hA4,       32'h14, 0, 0,  1,  1, 32'hA0,      32'h10, 2);
        va[7]  = mk(1, 32'hBAD,      32'h99, 0, 0,  0,  1, 32'hA0,      32'h10, 2);
        va[8]  = mk(0, 32'h0,        32'h0,  1, 0,  0,  1, 32'hA4,      32'h14, 1);
        va[9]  = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'h0,       32'h0,  0);
        // Flush in TWO. 0x28 is refused, and 0x40 is the next delivered entry.
        va[10] = mk(1, 32'hC0,       32'h20, 0, 0,  1,  1, 32'hC0,      32'h20, 1);
        va[11] = mk(1, 32'hC4,       32'h24, 0, 0,  1,  1, 32'hC0,      32'h20, 2);
        va[12] = mk(1, 32'hC8,       32'h28, 0, 1,  0,  0, 32'h0,       32'h0,  0);
        va[13] = mk(1, 32'hD0,       32'h40, 0, 0,  1,  1, 32'hD0,      32'h40, 1);
        va[14] = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'h0,       32'h0,  0);
        // Flush and consume in the same cycle. The entry is squashed and never reappears.
        va[15] = mk(1, 32'hE0,       32'h50, 1, 0,  1,  1, 32'hE0,      32'h50, 1);
        va[16] = mk(0, 32'h0,        32'h0,  1, 1,  0,  0, 32'h0,       32'h0,  0);
        va[17] = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'h0,       32'h0,  0);
        // In ONE with neither accept nor consume, the entry holds.
        va[18] = mk(1, 32'hF0,       32'h60, 0, 0,  1,  1, 32'hF0,      32'h60, 1);
        va[19] = mk(0, 32'h0,        32'h0,  0, 0,  1,  1, 32'hF0,      32'h60, 1);
        va[20] = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'h0,       32'h0,  0);

        // Narrow rising-edge instance: streaming, then flush in TWO.
        vb[0]  = mk(1, 32'h0011,     32'h0,  1, 0,  1,  1, 32'h0011,    32'h0,  1);
        vb[1]  = mk(1, 32'h0022,     32'h4,  1, 0,  1,  1, 32'h0022,    32'h4,  1);
        vb[2]  = mk(1, 32'h0033,     32'h8,  1, 0,  1,  1, 32'h0033,    32'h8,  1);
        vb[3]  = mk(1, 32'h0044,     32'hC,  1, 0,  1,  1, 32'h0044,    32'hC,  1);
        vb[4]  = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'hF000,    32'h0,  0);
        vb[5]  = mk(1, 32'h00C0,     32'h20, 0, 0,  1,  1, 32'h00C0,    32'h20, 1);
        vb[6]  = mk(1, 32'h00C4,     32'h24, 0, 0,  1,  1, 32'h00C0,    32'h20, 2);
        vb[7]  = mk(1, 32'h00C8,     32'h28, 0, 1,  0,  0, 32'hF000,    32'h0,  0);
        vb[8]  = mk(1, 32'h00D0,     32'h40, 1, 0,  1,  1, 32'h00D0,    32'h40, 1);
        vb[9]  = mk(0, 32'h0,        32'h0,  1, 0,  1,  0, 32'hF000,    32'h0,  0);

        // Reset held while fetch presents a valid instruction.
        rst_n = 1'b0;
        a_iv = 1'b1; a_ins = 32'hDEAD_BEEF; a_pc = 32'h0000_1234; a_ordy = 1'b1; a_fl = 1'b0;
        b_iv = 1'b0; b_ins = 16'h0; b_pc = 12'h0; b_ordy = 1'b0; b_fl = 1'b0;
        #12;
        chk("rst.a.vld", {31'b0, a_vld}, 32'h0);
        chk("rst.a.ins", a_oins, 32'h0);
        chk("rst.a.pc",  a_opc,  32'h0);
        chk("rst.a.occ", {30'b0, a_occ}, 32'h0);
        chk("rst.a.rdy", {31'b0, a_rdy}, 32'h0);
        chk("rst.b.ins", {16'b0, b_oins}, 32'hF000);
        chk("rst.b.rdy", {31'b0, b_rdy}, 32'h0);
        #11;                       // t=23, away from both edges
        rst_n = 1'b1;
        #1;
        chk("rel.a.rdy", {31'b0, a_rdy}, 32'h1);
        chk("rel.b.rdy", {31'b0, b_rdy}, 32'h1);
        a_iv = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 21; i++) apply_a($sformatf("a%0d", i), va[i]);

        // Long stall in TWO: the output must hold for several cycles.
        apply_a("s0", mk(1, 32'h81, 32'h80, 0, 0, 1, 1, 32'h81, 32'h80, 1));
        apply_a("s1", mk(1, 32'h85, 32'h84, 0, 0, 1, 1, 32'h81, 32'h80, 2));
        for (int k = 0; k < 5; k++)
            apply_a($sformatf("hold%0d", k), mk(1, 32'h99, 32'h88, 0, 0, 0, 1, 32'h81, 32'h80, 2));

        // Reset asserted mid-operation takes effect immediately, with no clock edge.
        rst_n = 1'b0;
        #1;
        chk("mid.vld", {31'b0, a_vld}, 32'h0);
        chk("mid.occ", {30'b0, a_occ}, 32'h0);
        chk("mid.pc",  a_opc, 32'h0);
        chk("mid.rdy", {31'b0, a_rdy}, 32'h0);
        #1;
        rst_n = 1'b1;
        a_iv = 1'b0;
        @(posedge clock); #1;
        apply_a("post0", mk(1, 32'h77, 32'h70, 1, 0, 1, 1, 32'h77, 32'h70, 1));
        apply_a("post1", mk(0, 32'h0,  32'h0,  1, 0, 1, 0, 32'h0,  32'h0,  0));

        a_iv = 1'b0; a_ordy = 1'b0; a_fl = 1'b0;
        for (int i = 0; i < 10; i++) apply_b($sformatf("b%0d", i), vb[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
Parametrised IF/ID pipeline boundary register. It replaces the bare instruction/PC latch with a valid/ready handshake and a two-entry skid. This lets the decode stage stall and lets a taken branch flush the stage without dropping or duplicating fetched instructions. It sits between instruction memory/fetch and the decode/register-file stage.

Parameters:
INSTR_W, 32, instruction width in bits
PC_W, 32, program-counter width in bits
NOP_INSTR, 32'h0000_0000, value driven on out_instruction when the stage holds no valid entry (INSTR_W bits)
NEGEDGE_CAPTURE, 1, 1 = all state updates on falling clock edge, 0 = rising edge

Ports:
clock  in  1  stage clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents a valid instruction/PC
in_ready  out  1  buffer can accept this cycle
instruction  in  INSTR_W  fetched instruction
PC  in  PC_W  PC of fetched instruction
out_valid  out  1  out_instruction/out_PC hold a valid entry
out_ready  in  1  decode consumes the entry this cycle
out_instruction  out  INSTR_W  instruction to decode
out_PC  out  PC_W  PC to decode
flush  in  1  synchronous squash of all held entries
occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset_n` is asynchronous and active-low. Active edge is selected by NEGEDGE_CAPTURE (default falling edge).
- Reset (reset_n=0, immediate, independent of clock): out_valid=0, out_instruction=NOP_INSTR, out_PC=0, skid cleared, occupancy=0, in_ready=0. in_ready rises only after reset_n=1.
- Storage: main entry {instr, pc, valid}, which drives the outputs directly; skid entry {instr, pc, valid}.
- Outputs are registered, with no combinational path from the inputs to out_*.
- in_ready = reset_n & ~skid.valid & ~flush. It has no dependence on out_ready.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- States: EMPTY (occupancy 0), ONE (1), TWO (2). Transitions at the active edge:
  - EMPTY: accept -> ONE, main<=input. Otherwise stay EMPTY.
  - ONE, consume & accept -> ONE, main<=input.
  - ONE, consume & ~accept -> EMPTY, main instr<=NOP_INSTR, pc<=0.
  - ONE, ~consume & accept -> TWO, skid<=input, main unchanged.
  - ONE, neither -> hold.
  - TWO (in_ready=0): consume -> ONE, main<=skid, skid cleared. Otherwise hold.
- Ordering: entries leave in acceptance order. No entry is ever dropped or duplicated except by flush.
- Flush (sampled at the active edge): takes priority over accept and consume.
  - Next state EMPTY: main and skid cleared, out_instruction=NOP_INSTR, out_PC=0.
  - in_ready is 0 during the flush cycle, so no input is accepted.
  - An out_ready in the same cycle as flush is ignored and the entry counts as squashed.
- Stall: out_ready=0 holds out_instruction and out_PC stable for any number of cycles.
- Throughput: one entry per cycle sustained when out_ready=1. Latency in->out is 1 active edge.
- X-safety: when in_valid=0, instruction and PC values are don't-care and are never captured.
- Reset asserted mid-operation discards all entries immediately. The first accept after release behaves as from EMPTY.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, instruction=32'hDEAD_BEEF -> out_valid=0, out_instruction=0, out_PC=0, occupancy=0, in_ready=0. Release -> in_ready=1 before the next active edge.
- Streaming: out_ready=1, feed PC=0,4,8,12 with instructions 32'h11..32'h44, one per cycle -> each appears exactly 1 active edge later, in order, occupancy stays 1.
- Stall with skid: accept PC=0x10, then drop out_ready to 0 while feeding PC=0x14 -> occupancy=2, in_ready=0, out_PC held at 0x10. Raise out_ready -> 0x10 then 0x14 delivered, occupancy returns to 1 then 0.
- Flush in TWO: occupancy=2 (PCs 0x20, 0x24), assert flush with in_valid=1, PC=0x28 -> next edge occupancy=0, out_valid=0, out_instruction=NOP_INSTR. 0x28 is not accepted. The next accepted PC (0x40) is the first delivered.
- Flush+consume same cycle: occupancy=1, out_ready=1, flush=1 -> stage EMPTY, entry not counted as delivered, no duplicate on the following cycle.
- Mode sweep: NEGEDGE_CAPTURE=0, INSTR_W=16, PC_W=12, NOP_INSTR=16'hF000 -> repeat the streaming and flush scenarios on rising edges, with out_instruction=16'hF000 when empty.
